// File: rtl/wavetable_voice_reader.sv
// wavetable_voice_reader: time-multiplexed NCO front end for a wavetable ROM.
// Three cycles per voice: read sample A, read sample B, interpolate and advance.
module wavetable_voice_reader #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int TABLE_BITS = 7,
    parameter int NUM_TABLES = 5,
    parameter int ADDR_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_voice,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [2:0]         cfg_wave,
    output logic               rom_re,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               out_valid,
    output logic [3:0]         out_voice,
    output logic [7:0]         out_sample,
    output logic               busy,
    output logic               overrun
);
    localparam logic [2:0] LAST_TABLE = 3'(NUM_TABLES - 1);
    localparam logic [3:0] LAST_VOICE = 4'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, CAP_B} state_t;
    state_t r_state, w_next;

    logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
    logic [PHASE_W-1:0]    r_inc   [NUM_VOICES];
    logic [2:0]            r_wave  [NUM_VOICES];
    logic [3:0]            r_v;
    logic [PHASE_W-1:0]    r_cur_phase;
    logic [PHASE_W-1:0]    r_cur_inc;
    logic [2:0]            r_cur_wave;
    logic [7:0]            r_s0;
    logic [ADDR_W-1:0]     r_addr_hold;
    logic                  r_out_valid;
    logic [3:0]            r_out_voice;
    logic [7:0]            r_out_sample;
    logic                  r_overrun;

    logic [PHASE_W-1:0]    w_sel_phase;
    logic [PHASE_W-1:0]    w_sel_inc;
    logic [2:0]            w_sel_wave;
    logic [TABLE_BITS-1:0] w_idx_a;
    logic [TABLE_BITS-1:0] w_idx_b;
    logic [7:0]            w_frac;
    logic [2:0]            w_weff_a;
    logic [2:0]            w_weff_b;
    logic [ADDR_W-1:0]     w_addr_a;
    logic [ADDR_W-1:0]     w_addr_b;
    logic signed [8:0]     w_diff;
    logic signed [17:0]    w_prod;
    logic signed [17:0]    w_shift;
    logic [7:0]            w_interp;

    always_comb begin
        w_sel_phase = r_phase[0];
        w_sel_inc   = r_inc[0];
        w_sel_wave  = r_wave[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_v == 4'(i)) begin
                w_sel_phase = r_phase[i];
                w_sel_inc   = r_inc[i];
                w_sel_wave  = r_wave[i];
            end
        end
    end

    // Address A uses the live voice state; B uses the copy latched in RD_A.
    assign w_idx_a  = w_sel_phase[PHASE_W-1 -: TABLE_BITS];
    assign w_idx_b  = r_cur_phase[PHASE_W-1 -: TABLE_BITS] + 1'b1;
    assign w_frac   = r_cur_phase[PHASE_W-TABLE_BITS-1 -: 8];
    assign w_weff_a = (w_sel_wave > LAST_TABLE) ? LAST_TABLE : w_sel_wave;
    assign w_weff_b = (r_cur_wave > LAST_TABLE) ? LAST_TABLE : r_cur_wave;
    assign w_addr_a = (ADDR_W'(w_weff_a) << TABLE_BITS) | ADDR_W'(w_idx_a);
    assign w_addr_b = (ADDR_W'(w_weff_b) << TABLE_BITS) | ADDR_W'(w_idx_b);

    // Result lies between s0 and s1, so the 8-bit wrap of the sum is exact.
    assign w_diff   = $signed({1'b0, rom_data}) - $signed({1'b0, r_s0});
    assign w_prod   = w_diff * $signed({1'b0, w_frac});
    assign w_shift  = w_prod >>> 8;
    assign w_interp = r_s0 + w_shift[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (sample_tick) w_next = RD_A;
            RD_A:    w_next = RD_B;
            RD_B:    w_next = CAP_B;
            CAP_B:   w_next = (r_v == LAST_VOICE) ? IDLE : RD_A;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        rom_re   = 1'b0;
        rom_addr = r_addr_hold;
        busy     = (r_state != IDLE);
        unique case (r_state)
            RD_A: begin
                rom_re   = 1'b1;
                rom_addr = w_addr_a;
            end
            RD_B: begin
                rom_re   = 1'b1;
                rom_addr = w_addr_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v          <= '0;
            r_cur_phase  <= '0;
            r_cur_inc    <= '0;
            r_cur_wave   <= '0;
            r_s0         <= '0;
            r_addr_hold  <= '0;
            r_out_valid  <= 1'b0;
            r_out_voice  <= '0;
            r_out_sample <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_addr_hold <= rom_addr;
            r_overrun   <= sample_tick && busy;
            r_out_valid <= 1'b0;
            unique case (r_state)
                IDLE: if (sample_tick) r_v <= '0;
                RD_A: begin
                    r_cur_phase <= w_sel_phase;
                    r_cur_inc   <= w_sel_inc;
                    r_cur_wave  <= w_sel_wave;
                end
                RD_B: r_s0 <= rom_data;
                CAP_B: begin
                    r_out_sample <= w_interp;
                    r_out_voice  <= r_v;
                    r_out_valid  <= 1'b1;
                    if (r_v != LAST_VOICE) r_v <= r_v + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_inc[i]   <= '0;
                r_wave[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cfg_we && cfg_voice == 4'(i)) begin
                    r_inc[i]  <= cfg_inc;
                    r_wave[i] <= cfg_wave;
                end
                if (r_state == CAP_B && r_v == 4'(i))
                    r_phase[i] <= r_cur_phase + r_cur_inc;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_voice  = r_out_voice;
    assign out_sample = r_out_sample;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_wavetable_voice_reader.sv
// tb_wavetable_voice_reader: directed bench with a synchronous ROM model.
// Each sweep records addresses, outputs, busy and overrun for checking.
module tb_wavetable_voice_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        cfg_we;
    logic [3:0]  cfg_voice;
    logic [23:0] cfg_inc;
    logic [2:0]  cfg_wave;
    logic        rom_re;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic [3:0]  out_voice;
    logic [7:0]  out_sample;
    logic        busy;
    logic        overrun;

    logic [7:0]  rom [0:1023];
    int          checks = 0;
    int          failures = 0;
    int          addr_q[$];
    int          samp_q[$];
    int          voice_q[$];
    int          busy_cnt;
    int          ov_cnt;
    logic        last_busy;

    wavetable_voice_reader dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_inc(cfg_inc),
        .cfg_wave(cfg_wave), .rom_re(rom_re), .rom_addr(rom_addr),
        .rom_data(rom_data), .out_valid(out_valid), .out_voice(out_voice),
        .out_sample(out_sample), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_re) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int v, input logic [23:0] inc, input int w);
        cfg_we    = 1'b1;
        cfg_voice = 4'(v);
        cfg_inc   = inc;
        cfg_wave  = 3'(w);
        step();
        cfg_we    = 1'b0;
    endtask

    // Tick, then sample 14 cycles; optionally re-tick after cycle retick.
    task automatic sweep(input int retick);
        addr_q.delete();
        samp_q.delete();
        voice_q.delete();
        busy_cnt = 0;
        ov_cnt   = 0;
        sample_tick = 1'b1;
        step();
        for (int i = 1; i <= 14; i++) begin
            sample_tick = (i == retick);
            if (rom_re)    addr_q.push_back(int'(rom_addr));
            if (out_valid) begin
                samp_q.push_back(int'(out_sample));
                voice_q.push_back(int'(out_voice));
            end
            if (busy)    busy_cnt++;
            if (overrun) ov_cnt++;
            last_busy = busy;
            if (i < 14) step();
        end
        sample_tick = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) step();
        chk("drain_idle", 32'(busy), 0);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom[k] = 8'(k);
        rst = 1'b1; sample_tick = 0; cfg_we = 0;
        cfg_voice = 0; cfg_inc = 0; cfg_wave = 0;
        repeat (3) step();
        chk("rst_rom_re", 32'(rom_re), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        step();

        // 1: plain sweep, all voices idx 0 of table 0
        sweep(-1);
        chk("t1_naddr", 32'(addr_q.size()), 8);
        for (int v = 0; v < 4; v++) begin
            chk("t1_addrA", 32'(addr_q[2*v]), 0);
            chk("t1_addrB", 32'(addr_q[2*v+1]), 1);
            chk("t1_voice", 32'(voice_q[v]), 32'(v));
            chk("t1_samp", 32'(samp_q[v]), 0);
        end
        chk("t1_busy", 32'(busy_cnt), 12);
        chk("t1_nout", 32'(samp_q.size()), 4);

        // 2: voice0 wave 2, idx 0, frac 0x80
        rom[256] = 8'h10; rom[257] = 8'h30;
        cfg(0, 24'h010000, 2);
        sweep(-1);
        chk("t2_addrA", 32'(addr_q[0]), 256);
        chk("t2_addrB", 32'(addr_q[1]), 257);
        chk("t2_frac0", 32'(samp_q[0]), 32'h10);
        cfg(0, 24'h0, 2);
        sweep(-1);
        chk("t2_up", 32'(samp_q[0]), 32'h20);
        rom[256] = 8'h30; rom[257] = 8'h10;
        sweep(-1);
        chk("t2_down", 32'(samp_q[0]), 32'h20);
        rom[256] = 8'hFF; rom[257] = 8'h00;
        sweep(-1);
        chk("t2_floor", 32'(samp_q[0]), 32'h7F);

        // 3: voice1 wave 1 at idx 127 wraps inside its table
        cfg(1, 24'hFE0000, 1);
        sweep(-1);
        chk("t3_pre_addr", 32'(addr_q[2]), 128);
        cfg(1, 24'h0, 1);
        sweep(-1);
        chk("t3_addrA", 32'(addr_q[2]), 255);
        chk("t3_addrB", 32'(addr_q[3]), 128);
        chk("t3_samp", 32'(samp_q[1]), 32'hFF);
        chk("t3_voice", 32'(voice_q[1]), 1);

        // 4: wave 7 clamps to table 4; out-of-range voice write ignored
        rom[512] = 8'h5A;
        cfg(2, 24'h0, 7);
        cfg(4, 24'h123456, 3);
        sweep(-1);
        chk("t4_addrA", 32'(addr_q[4]), 512);
        chk("t4_addrB", 32'(addr_q[5]), 513);
        chk("t4_samp", 32'(samp_q[2]), 32'h5A);
        chk("t4_v0_addr", 32'(addr_q[0]), 256);
        chk("t4_v3_addr", 32'(addr_q[6]), 0);

        // 5: overrun on early and on boundary ticks; 13 cycles is accepted
        sweep(5);
        chk("t5_ov", 32'(ov_cnt), 1);
        chk("t5_nout", 32'(samp_q.size()), 4);
        chk("t5_voice3", 32'(voice_q[3]), 3);
        chk("t5_busy", 32'(busy_cnt), 12);
        sweep(12);
        chk("t5b_ov", 32'(ov_cnt), 1);
        chk("t5b_idle", 32'(last_busy), 0);
        sweep(13);
        chk("t5c_ov", 32'(ov_cnt), 0);
        chk("t5c_restart", 32'(last_busy), 1);
        chk("t5c_addr", 32'(addr_q[8]), 256);
        drain();

        // 6: reset in RD_B of voice 2 aborts; restart from phase 0
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (7) step();
        chk("t6_rdb_addr", 32'(rom_addr), 513);
        chk("t6_rdb_re", 32'(rom_re), 1);
        rst = 1'b1;
        #1;
        chk("t6_re", 32'(rom_re), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_valid", 32'(out_valid), 0);
        step();
        rst = 1'b0;
        step();
        rom[256] = 8'hC3;
        cfg(0, 24'h0, 2);
        sweep(-1);
        chk("t6_addr", 32'(addr_q[0]), 256);
        chk("t6_voice", 32'(voice_q[0]), 0);
        chk("t6_samp", 32'(samp_q[0]), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
